c4_seq_ctrl: RTL and testbench

Controller that configures and exercises the `c4` state-machine core. It sits between a host/test harness and `c4`. On a start pulse it shifts a configuration word into `c4` serially (`m`=1, `SDI`), then returns `c4` to normal mode. It then plays a programmed stimulus sequence on `a` and checks the `c4` outputs `s`,`t` against expected values each step, reporting pass/fail and the first failing step.

---
 rtl/c4_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_c4_seq_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/c4_seq_ctrl.sv
// c4_seq_ctrl: scan-configures the c4 core, then plays and checks a stimulus sequence (C4_CTRL_ABORT_EN: stop at first mismatch)
module c4_seq_ctrl #(
   parameter int SCAN_W  = 4,
   parameter int SEQ_LEN = 8,
   parameter int STEP_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
   input  logic                 n_clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [SCAN_W-1:0]    cfg_word,
   input  logic [SEQ_LEN-1:0]   pat_a,
   input  logic [2*SEQ_LEN-1:0] exp_st,
   input  logic                 s,
   input  logic                 t,
   output logic                 SDI,
   output logic                 m,
   output logic                 c,
   output logic                 a,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [STEP_W-1:0]    err_step
);
   localparam int BIT_W = (SCAN_W > 1) ? $clog2(SCAN_W) : 1;
   typedef enum logic [2:0] {IDLE, SHIFT, SETTLE, RUN, DONE} state_e;
   state_e               state_q;
   logic [SCAN_W-1:0]    cfg_q;
   logic [SEQ_LEN-1:0]   pat_q;
   logic [2*SEQ_LEN-1:0] exp_q;
   logic [BIT_W-1:0]     bit_q;
   logic [STEP_W-1:0]    step_q, step_d, err_q;
   logic                 sdi_q, m_q, c_q, a_q, busy_q, done_q, pass_q;
   logic                 miss_d, last_d, stop_d;
   // current-step check against the head of the expectation shift register
   always_comb begin
      step_d = step_q + 1'b1;
      miss_d = {s, t} != exp_q[1:0];
      last_d = step_q == STEP_W'(SEQ_LEN - 1);
`ifdef C4_CTRL_ABORT_EN
      stop_d = last_d || miss_d;
`else
      stop_d = last_d;
`endif
   end
   // sequencer: config/stimulus are consumed from shift registers so no variable indexing is needed
   always_ff @(negedge n_clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cfg_q   <= '0;
         pat_q   <= '0;
         exp_q   <= '0;
         bit_q   <= '0;
         step_q  <= '0;
         err_q   <= '0;
         sdi_q   <= 1'b0;
         m_q     <= 1'b0;
         c_q     <= 1'b1;
         a_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               cfg_q   <= cfg_word << 1;
               pat_q   <= pat_a;
               exp_q   <= exp_st;
               sdi_q   <= cfg_word[SCAN_W-1];
               m_q     <= 1'b1;
               c_q     <= 1'b0;
               busy_q  <= 1'b1;
               pass_q  <= 1'b1;
               err_q   <= '0;
               bit_q   <= '0;
               step_q  <= '0;
               state_q <= SHIFT;
            end
            SHIFT: if (bit_q == BIT_W'(SCAN_W - 1)) begin
               sdi_q   <= 1'b0;
               m_q     <= 1'b0;
               c_q     <= 1'b1;
               state_q <= SETTLE;
            end else begin
               sdi_q <= cfg_q[SCAN_W-1];
               cfg_q <= cfg_q << 1;
               bit_q <= bit_q + 1'b1;
            end
            SETTLE: begin
               a_q     <= pat_q[0];
               pat_q   <= pat_q >> 1;
               state_q <= RUN;
            end
            RUN: begin
               if (miss_d && pass_q) begin
                  pass_q <= 1'b0;
                  err_q  <= step_q;
               end
               if (stop_d) begin
                  a_q     <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  a_q    <= pat_q[0];
                  pat_q  <= pat_q >> 1;
                  exp_q  <= exp_q >> 2;
                  step_q <= step_d;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign SDI      = sdi_q;
   assign m        = m_q;
   assign c        = c_q;
   assign a        = a_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign err_step = err_q;
endmodule

// File: tb/tb_c4_seq_ctrl.sv
// tb_c4_seq_ctrl: randomized self-checking bench for c4_seq_ctrl against a cycle-schedule reference model
module tb_c4_seq_ctrl;
   localparam int SCAN_W  = 4;
   localparam int SEQ_LEN = 8;
   localparam int STEP_W  = 3;
   logic                 n_clk = 1'b1, rst = 1'b0, start = 1'b0, s = 1'b0, t = 1'b0;
   logic [SCAN_W-1:0]    cfg_word = '0;
   logic [SEQ_LEN-1:0]   pat_a = '0;
   logic [2*SEQ_LEN-1:0] exp_st = '0;
   logic                 SDI, m, c, a, busy, done, pass;
   logic [STEP_W-1:0]    err_step;
   int                   n_chk = 0, n_fail = 0;
   c4_seq_ctrl #(.SCAN_W(SCAN_W), .SEQ_LEN(SEQ_LEN)) dut (
      .n_clk(n_clk), .rst(rst), .start(start), .cfg_word(cfg_word), .pat_a(pat_a),
      .exp_st(exp_st), .s(s), .t(t), .SDI(SDI), .m(m), .c(c), .a(a), .busy(busy),
      .done(done), .pass(pass), .err_step(err_step)
   );
   always #5 n_clk = ~n_clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask
   // one run; cycle cy is the cycle following edge E0+cy, where E0 accepts start
   task automatic run_seq(input logic [SCAN_W-1:0] cfg, input logic [SEQ_LEN-1:0] pat,
                          input logic [2*SEQ_LEN-1:0] ex, input logic [2*SEQ_LEN-1:0] act,
                          input int busy_at, input int rst_at);
      int e, nsteps, dc;
      logic [5:0] want;
      logic [31:0] res;
      e = -1;
      for (int i = SEQ_LEN - 1; i >= 0; i--) if (act[2*i +: 2] != ex[2*i +: 2]) e = i;
      nsteps = SEQ_LEN;
`ifdef C4_CTRL_ABORT_EN
      if (e >= 0) nsteps = e + 1;
`endif
      dc  = SCAN_W + 1 + nsteps;
      res = (e < 0) ? 32'h8 : 32'(e);
      @(posedge n_clk);
      cfg_word = cfg;
      pat_a    = pat;
      exp_st   = ex;
      start    = 1'b1;
      @(negedge n_clk);
      #1;
      cfg_word = SCAN_W'($urandom);
      pat_a    = SEQ_LEN'($urandom);
      exp_st   = (2*SEQ_LEN)'($urandom);
      for (int cy = 0; cy <= dc + 1; cy++) begin
         if (cy >= SCAN_W + 1 && cy < SCAN_W + 1 + SEQ_LEN) {s, t} = act[2*(cy-SCAN_W-1) +: 2];
         else {s, t} = 2'($urandom);
         start = (cy == SCAN_W + 1 + busy_at) || (cy == dc);
         @(posedge n_clk);
         #1;
         if (cy == rst_at) begin
            rst = 1'b0;
            #1;
            check("rst_async_outs", 32'({SDI, m, c, a, busy, done}), 32'b001000);
            check("rst_async_res", 32'({pass, err_step}), 32'h0);
            start = 1'b0;
            @(negedge n_clk);
            #1;
            rst = 1'b1;
            return;
         end
         if (cy < SCAN_W) want = {cfg[SCAN_W-1-cy], 5'b10010};
         else if (cy == SCAN_W) want = 6'b001010;
         else if (cy < dc) want = {3'b001, pat[cy-SCAN_W-1], 2'b10};
         else if (cy == dc) want = 6'b001001;
         else want = 6'b001000;
         check("outs_SDI_m_c_a_busy_done", 32'(want), 32'({SDI, m, c, a, busy, done}) == 32'(want) ? 32'(want) : 32'({SDI, m, c, a, busy, done}) ^ 32'h0);
         if (cy == dc) check("result_pass_err", 32'({pass, err_step}), res);
         if (cy == dc + 1) check("result_hold", 32'({pass, err_step}), res);
         @(negedge n_clk);
         #1;
      end
      start = 1'b0;
   endtask
   logic [2*SEQ_LEN-1:0] ex, act;
   initial begin
      repeat (2) @(posedge n_clk);
      #1;
      check("reset_outs", 32'({SDI, m, c, a, busy, done}), 32'b001000);
      check("reset_res", 32'({pass, err_step}), 32'h0);
      rst = 1'b1;
      ex = 16'hA5C3;
      run_seq(4'b0011, 8'b0001_1110, ex, ex, -100, -1);
      act = ex ^ (16'h3 << 10);
      run_seq(4'b0011, 8'b0001_1110, ex, act, -100, -1);
      act = ex ^ (16'h1 << 12) ^ (16'h2 << 4);
      run_seq(4'b1010, 8'b1100_0101, ex, act, -100, -1);
      run_seq(4'b0110, 8'b0101_0011, ex, ex, 2, -1);
      run_seq(4'b1001, 8'b1111_0000, ex, ex, -100, 2);
      run_seq(4'b1001, 8'b1111_0000, ex, ex, -100, -1);
      act = ex ^ 16'h1 ^ (16'h3 << 14);
      run_seq(4'b1111, 8'b1000_0001, ex, act, -100, -1);
      for (int n = 0; n < 20; n++) begin
         ex  = 16'($urandom);
         act = ex;
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < 2; k++) act[2*$urandom_range(0, SEQ_LEN-1) +: 2] ^= 2'($urandom_range(1, 3));
         end
         run_seq(SCAN_W'($urandom), SEQ_LEN'($urandom), ex, act, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -100, -1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
